delay_scan_sequencer: RTL and testbench

// Automatic per-link input-delay calibration engine for the bidirectional link IO bank. It scans each enabled link's

---
 rtl/delay_scan_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_delay_scan_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/delay_scan_sequencer.sv
// delay_scan_sequencer
//   Per-link input-delay calibration engine. Links are calibrated one at a
//   time, lowest index first. Each link's input delay is stepped from tap 0
//   upward. At every scan point the link's error counter is cleared and
//   allowed to accumulate for a dwell period, then it is sampled. The centre
//   of the longest error-free run of taps is then programmed into the link.
// Ports
//   clk160           calibration clock
//   rst              synchronous active-high reset (aborts a run, clears results)
//   start            one-cycle run request, ignored while busy
//   link_mask        links to calibrate, captured when start is accepted
//   busy / done      run in progress / one-cycle end-of-run pulse
//   link_ok          per-link: a non-empty error-free window was found and applied
//   link_delay       per-link chosen tap, link i at [i*DELAY_W +: DELAY_W]
//   delay_set        per-link one-cycle load strobe for delay_in
//   delay_mode       per-link load mode, always fixed-tap (0)
//   delay_in         per-link tap value, valid with delay_set, held between loads
//   reset_counters   per-link one-cycle error-counter clear
//   delay_ready      per-link delay-line ready
//   bit_align_errors per-link 16-bit error count, link i at [i*16 +: 16]
module delay_scan_sequencer #(
  parameter int NLINKS        = 12,
  parameter int DELAY_W       = 9,
  parameter int DELAY_MAX     = 511,
  parameter int DELAY_STEP    = 8,
  parameter int DWELL_CYCLES  = 4096,
  parameter int READY_TIMEOUT = 1024
) (
  input  logic                       clk160,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NLINKS-1:0]          link_mask,
  output logic                       busy,
  output logic                       done,
  output logic [NLINKS-1:0]          link_ok,
  output logic [NLINKS*DELAY_W-1:0]  link_delay,
  output logic [NLINKS-1:0]          delay_set,
  output logic [NLINKS-1:0]          delay_mode,
  output logic [NLINKS*DELAY_W-1:0]  delay_in,
  output logic [NLINKS-1:0]          reset_counters,
  input  logic [NLINKS-1:0]          delay_ready,
  input  logic [NLINKS*16-1:0]       bit_align_errors
);

  localparam int LINK_W = (NLINKS > 1) ? $clog2(NLINKS) : 1;
  localparam int LEN_W  = DELAY_W + 1;
  localparam int CEN_W  = DELAY_W + 8;
  localparam int TO_W   = $clog2(READY_TIMEOUT + 1);
  localparam int DWL_W  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_NEXT_LINK   = 4'd1,
    ST_SET_DELAY   = 4'd2,
    ST_WAIT_READY  = 4'd3,
    ST_CLR_CNT     = 4'd4,
    ST_DWELL       = 4'd5,
    ST_SAMPLE      = 4'd6,
    ST_FINISH_LINK = 4'd7,
    ST_APPLY       = 4'd8,
    ST_WAIT_APPLY  = 4'd9,
    ST_DONE        = 4'd10
  } state_t;

  state_t                    state_r, state_next_s;
  logic [NLINKS-1:0]         mask_r, mask_next_s;
  logic [LINK_W-1:0]         link_r, link_next_s;
  logic [DELAY_W-1:0]        tap_r, tap_next_s;
  logic [TO_W-1:0]           wait_r, wait_next_s;
  logic [DWL_W-1:0]          dwell_r, dwell_next_s;
  logic [DELAY_W-1:0]        cur_start_r, cur_start_next_s;
  logic [LEN_W-1:0]          cur_len_r, cur_len_next_s;
  logic [DELAY_W-1:0]        best_start_r, best_start_next_s;
  logic [LEN_W-1:0]          best_len_r, best_len_next_s;
  logic [DELAY_W-1:0]        centre_r, centre_next_s;

  logic                      busy_next_s, done_next_s;
  logic [NLINKS-1:0]         link_ok_next_s, delay_set_next_s, reset_counters_next_s;
  logic [NLINKS*DELAY_W-1:0] link_delay_next_s, delay_in_next_s;

  logic                      low_found_s;
  logic [LINK_W-1:0]         low_idx_s;
  logic [15:0]               sel_err_s;
  logic                      sel_ready_s;
  logic                      ready_ok_s, timeout_s;
  logic [31:0]               tap_sum_s;
  logic [DELAY_W-1:0]        run_start_s;
  logic [LEN_W-1:0]          run_len_s;
  logic [CEN_W-1:0]          centre_off_s;

  assign delay_mode = '0;

  // Lowest-index link still pending in the captured mask.
  always_comb begin
    low_found_s = 1'b0;
    low_idx_s   = '0;
    for (int i = NLINKS - 1; i >= 0; i--) begin
      if (mask_r[i]) begin
        low_found_s = 1'b1;
        low_idx_s   = LINK_W'(i);
      end else begin
        low_idx_s   = low_idx_s;
      end
    end
  end

  // Select the error count and ready flag of the link being calibrated.
  always_comb begin
    sel_err_s   = 16'd0;
    sel_ready_s = 1'b0;
    for (int i = 0; i < NLINKS; i++) begin
      if (link_r == LINK_W'(i)) begin
        sel_err_s   = bit_align_errors[i*16 +: 16];
        sel_ready_s = delay_ready[i];
      end else begin
        sel_ready_s = sel_ready_s;
      end
    end
  end

  // The wait counter is 1 in the first cycle after the load strobe, so
  // ">= 2" means at least two cycles have elapsed since the load.
  assign ready_ok_s   = sel_ready_s && (wait_r >= TO_W'(2));
  assign timeout_s    = (wait_r >= TO_W'(READY_TIMEOUT));
  assign tap_sum_s    = 32'(tap_r) + 32'(DELAY_STEP);
  // A passing point either opens a new run at the current tap or extends one.
  assign run_start_s  = (cur_len_r == '0) ? tap_r : cur_start_r;
  assign run_len_s    = cur_len_r + LEN_W'(1);
  // Half the span between first and last passing tap, floor-truncated.
  assign centre_off_s = ((CEN_W'(best_len_r) - CEN_W'(1)) * CEN_W'(DELAY_STEP)) >> 1;

  // Next-state, window bookkeeping and next output values.
  always_comb begin
    state_next_s          = state_r;
    mask_next_s           = mask_r;
    link_next_s           = link_r;
    tap_next_s            = tap_r;
    wait_next_s           = wait_r;
    dwell_next_s          = dwell_r;
    cur_start_next_s      = cur_start_r;
    cur_len_next_s        = cur_len_r;
    best_start_next_s     = best_start_r;
    best_len_next_s       = best_len_r;
    centre_next_s         = centre_r;
    link_ok_next_s        = link_ok;
    link_delay_next_s     = link_delay;
    delay_in_next_s       = delay_in;
    delay_set_next_s      = '0;
    reset_counters_next_s = '0;
    done_next_s           = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          mask_next_s       = link_mask;
          link_ok_next_s    = '0;
          cur_start_next_s  = '0;
          cur_len_next_s    = '0;
          best_start_next_s = '0;
          best_len_next_s   = '0;
          state_next_s      = ST_NEXT_LINK;
        end else begin
          state_next_s      = ST_IDLE;
        end
      end
      ST_NEXT_LINK: begin
        if (low_found_s) begin
          link_next_s                 = low_idx_s;
          mask_next_s[low_idx_s]      = 1'b0;
          tap_next_s                  = '0;
          cur_start_next_s            = '0;
          cur_len_next_s              = '0;
          best_start_next_s           = '0;
          best_len_next_s             = '0;
          delay_set_next_s[low_idx_s] = 1'b1;
          delay_in_next_s[int'(low_idx_s)*DELAY_W +: DELAY_W] = '0;
          state_next_s                = ST_SET_DELAY;
        end else begin
          done_next_s                 = 1'b1;
          state_next_s                = ST_DONE;
        end
      end
      ST_SET_DELAY: begin
        wait_next_s  = TO_W'(1);
        state_next_s = ST_WAIT_READY;
      end
      ST_WAIT_READY: begin
        if (ready_ok_s) begin
          reset_counters_next_s[link_r] = 1'b1;
          state_next_s                  = ST_CLR_CNT;
        end else if (timeout_s) begin
          link_ok_next_s[link_r]        = 1'b0;
          state_next_s                  = ST_NEXT_LINK;
        end else begin
          wait_next_s                   = wait_r + TO_W'(1);
        end
      end
      ST_CLR_CNT: begin
        dwell_next_s = '0;
        state_next_s = ST_DWELL;
      end
      ST_DWELL: begin
        if (dwell_r == DWL_W'(DWELL_CYCLES - 1)) begin
          state_next_s = ST_SAMPLE;
        end else begin
          dwell_next_s = dwell_r + DWL_W'(1);
        end
      end
      ST_SAMPLE: begin
        if (sel_err_s == 16'd0) begin
          cur_start_next_s = run_start_s;
          cur_len_next_s   = run_len_s;
          // Strict compare: an equal-length later window never displaces the earlier one.
          if (run_len_s > best_len_r) begin
            best_start_next_s = run_start_s;
            best_len_next_s   = run_len_s;
          end else begin
            best_len_next_s   = best_len_r;
          end
        end else begin
          cur_len_next_s = '0;
        end
        if (tap_sum_s <= 32'(DELAY_MAX)) begin
          tap_next_s                = DELAY_W'(tap_sum_s);
          delay_set_next_s[link_r]  = 1'b1;
          delay_in_next_s[int'(link_r)*DELAY_W +: DELAY_W] = DELAY_W'(tap_sum_s);
          state_next_s              = ST_SET_DELAY;
        end else begin
          state_next_s              = ST_FINISH_LINK;
        end
      end
      ST_FINISH_LINK: begin
        if (best_len_r == '0) begin
          link_ok_next_s[link_r]   = 1'b0;
          state_next_s             = ST_NEXT_LINK;
        end else begin
          centre_next_s            = DELAY_W'(CEN_W'(best_start_r) + centre_off_s);
          delay_set_next_s[link_r] = 1'b1;
          delay_in_next_s[int'(link_r)*DELAY_W +: DELAY_W] =
            DELAY_W'(CEN_W'(best_start_r) + centre_off_s);
          state_next_s             = ST_APPLY;
        end
      end
      ST_APPLY: begin
        wait_next_s  = TO_W'(1);
        state_next_s = ST_WAIT_APPLY;
      end
      ST_WAIT_APPLY: begin
        if (ready_ok_s) begin
          link_delay_next_s[int'(link_r)*DELAY_W +: DELAY_W] = centre_r;
          link_ok_next_s[link_r] = 1'b1;
          state_next_s           = ST_NEXT_LINK;
        end else if (timeout_s) begin
          link_ok_next_s[link_r] = 1'b0;
          state_next_s           = ST_NEXT_LINK;
        end else begin
          wait_next_s            = wait_r + TO_W'(1);
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase

    busy_next_s = (state_next_s != ST_IDLE);
  end

  // State, bookkeeping and output registers; outputs are registered copies of next values.
  always_ff @(posedge clk160) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      mask_r         <= '0;
      link_r         <= '0;
      tap_r          <= '0;
      wait_r         <= '0;
      dwell_r        <= '0;
      cur_start_r    <= '0;
      cur_len_r      <= '0;
      best_start_r   <= '0;
      best_len_r     <= '0;
      centre_r       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      link_ok        <= '0;
      link_delay     <= '0;
      delay_set      <= '0;
      delay_in       <= '0;
      reset_counters <= '0;
    end else begin
      state_r        <= state_next_s;
      mask_r         <= mask_next_s;
      link_r         <= link_next_s;
      tap_r          <= tap_next_s;
      wait_r         <= wait_next_s;
      dwell_r        <= dwell_next_s;
      cur_start_r    <= cur_start_next_s;
      cur_len_r      <= cur_len_next_s;
      best_start_r   <= best_start_next_s;
      best_len_r     <= best_len_next_s;
      centre_r       <= centre_next_s;
      busy           <= busy_next_s;
      done           <= done_next_s;
      link_ok        <= link_ok_next_s;
      link_delay     <= link_delay_next_s;
      delay_set      <= delay_set_next_s;
      delay_in       <= delay_in_next_s;
      reset_counters <= reset_counters_next_s;
    end
  end

endmodule

// File: tb/tb_delay_scan_sequencer.sv
// Directed bench for delay_scan_sequencer. A small link model returns zero
// errors only when the tap last loaded into a link falls inside that link's
// configured passing window(s). Dwell and ready timeout are shortened so the
// full 0..511 scan stays short.
`timescale 1ns/1ps
module tb_delay_scan_sequencer;

  localparam int NL    = 12;
  localparam int DW    = 9;
  localparam int DMAX  = 511;
  localparam int STEP  = 8;
  localparam int DWELL = 4;
  localparam int RTO   = 32;

  logic              clk160 = 1'b0;
  logic              rst;
  logic              start;
  logic [NL-1:0]     link_mask;
  logic              busy, done;
  logic [NL-1:0]     link_ok;
  logic [NL*DW-1:0]  link_delay;
  logic [NL-1:0]     delay_set, delay_mode;
  logic [NL*DW-1:0]  delay_in;
  logic [NL-1:0]     reset_counters;
  logic [NL-1:0]     delay_ready;
  logic [NL*16-1:0]  bit_align_errors;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int win_lo_a[NL], win_hi_a[NL], win_lo_b[NL], win_hi_b[NL];
  int prog_tap[NL];
  int set_cnt[NL], clr_cnt[NL], snap_set[NL], snap_clr[NL];
  int fs_cyc[NL];
  int done_cnt   = 0;
  int onehot_bad = 0;
  int d0;

  delay_scan_sequencer #(
    .NLINKS(NL), .DELAY_W(DW), .DELAY_MAX(DMAX), .DELAY_STEP(STEP),
    .DWELL_CYCLES(DWELL), .READY_TIMEOUT(RTO)
  ) dut (
    .clk160(clk160), .rst(rst), .start(start), .link_mask(link_mask),
    .busy(busy), .done(done), .link_ok(link_ok), .link_delay(link_delay),
    .delay_set(delay_set), .delay_mode(delay_mode), .delay_in(delay_in),
    .reset_counters(reset_counters), .delay_ready(delay_ready),
    .bit_align_errors(bit_align_errors)
  );

  always #3 clk160 = ~clk160;

  always @(posedge clk160) cyc <= cyc + 1;

  // Link model: zero errors only inside a passing window.
  always_comb begin
    for (int i = 0; i < NL; i++) begin
      if ((prog_tap[i] >= win_lo_a[i] && prog_tap[i] <= win_hi_a[i]) ||
          (prog_tap[i] >= win_lo_b[i] && prog_tap[i] <= win_hi_b[i]))
        bit_align_errors[i*16 +: 16] = 16'd0;
      else
        bit_align_errors[i*16 +: 16] = 16'd7;
    end
  end

  // Strobe monitor, sampled just after the clock edge.
  always @(posedge clk160) begin
    #1;
    for (int i = 0; i < NL; i++) begin
      if (delay_set[i]) begin
        set_cnt[i] = set_cnt[i] + 1;
        prog_tap[i] = int'(delay_in[i*DW +: DW]);
      end
      if (reset_counters[i]) clr_cnt[i] = clr_cnt[i] + 1;
    end
    if ($countones(delay_set) > 1 || $countones(reset_counters) > 1) onehot_bad = onehot_bad + 1;
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ld(input int i);
    return int'(link_delay[i*DW +: DW]);
  endfunction

  task automatic snap();
    for (int i = 0; i < NL; i++) begin
      snap_set[i] = set_cnt[i];
      snap_clr[i] = clr_cnt[i];
    end
  endtask

  task automatic no_window(input int i);
    win_lo_a[i] = 1000; win_hi_a[i] = -1;
    win_lo_b[i] = 1000; win_hi_b[i] = -1;
  endtask

  // Called on a falling edge: pulse start, wait (bounded) for done, check idle.
  task automatic run_cal(input logic [NL-1:0] m, input int budget);
    int n;
    logic seen;
    for (int i = 0; i < NL; i++) fs_cyc[i] = -1;
    d0 = done_cnt;
    start = 1'b1; link_mask = m;
    @(negedge clk160);
    start = 1'b0; link_mask = '0;
    n = 0; seen = 1'b0;
    while (!seen && n < budget) begin
      for (int i = 0; i < NL; i++)
        if (delay_set[i] && fs_cyc[i] < 0) fs_cyc[i] = cyc;
      if (done) seen = 1'b1;
      @(negedge clk160);
      n++;
    end
    chk_val("done_seen", 32'(seen), 32'd1);
    @(negedge clk160);
    chk_val("idle_after_done", 32'(busy), 32'd0);
    chk_val("done_pulses", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int tot_set, tot_clr, n;
    logic found;
    rst = 1'b1; start = 1'b0; link_mask = '0; delay_ready = '1;
    for (int i = 0; i < NL; i++) no_window(i);
    repeat (3) @(negedge clk160);
    chk_val("rst_busy", 32'(busy), 32'd0);
    chk_val("rst_done", 32'(done), 32'd0);
    chk_val("rst_link_ok", 32'(link_ok), 32'd0);
    chk_val("rst_strobes", 32'(delay_set | reset_counters), 32'd0);
    chk_val("rst_delay_in", 32'(delay_in != '0), 32'd0);
    rst = 1'b0;
    @(negedge clk160);

    // Empty mask: busy cycles 1-2, done cycle 2, idle cycle 3, no strobes.
    snap();
    start = 1'b1; link_mask = '0;
    @(negedge clk160); start = 1'b0;
    chk_val("empty_c1_busy", 32'(busy), 32'd1);
    chk_val("empty_c1_done", 32'(done), 32'd0);
    @(negedge clk160);
    chk_val("empty_c2_busy", 32'(busy), 32'd1);
    chk_val("empty_c2_done", 32'(done), 32'd1);
    @(negedge clk160);
    chk_val("empty_c3_busy", 32'(busy), 32'd0);
    chk_val("empty_c3_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk160);
    tot_set = 0; tot_clr = 0;
    for (int i = 0; i < NL; i++) begin
      tot_set += set_cnt[i] - snap_set[i];
      tot_clr += clr_cnt[i] - snap_clr[i];
    end
    chk_val("empty_no_set", 32'(tot_set), 32'd0);
    chk_val("empty_no_clr", 32'(tot_clr), 32'd0);

    // Link0 passes taps 64..128 -> 9 points, centre 64+32 = 96.
    win_lo_a[0] = 64; win_hi_a[0] = 128;
    snap();
    run_cal(12'h001, 2000);
    chk_val("t1_link_ok", 32'(link_ok), 32'h001);
    chk_val("t1_delay0", 32'(ld(0)), 32'd96);
    chk_val("t1_delay_in0", 32'(delay_in[0 +: DW]), 32'd96);
    chk_val("t1_sets0", 32'(set_cnt[0] - snap_set[0]), 32'd65);
    chk_val("t1_clrs0", 32'(clr_cnt[0] - snap_clr[0]), 32'd64);
    chk_val("t1_sets1", 32'(set_cnt[1] - snap_set[1]), 32'd0);
    chk_val("t1_mode", 32'(delay_mode), 32'd0);

    // Link3: two 5-point windows, earliest (16..48) wins -> 16+16 = 32.
    win_lo_a[3] = 16; win_hi_a[3] = 48; win_lo_b[3] = 200; win_hi_b[3] = 232;
    snap();
    run_cal(12'h008, 2000);
    chk_val("t2_link_ok", 32'(link_ok), 32'h008);
    chk_val("t2_delay3", 32'(ld(3)), 32'd32);

    // Link2 always errors: not ok, delay untouched, scan loads only.
    no_window(2);
    snap();
    run_cal(12'h004, 2000);
    chk_val("t3_link_ok", 32'(link_ok), 32'h000);
    chk_val("t3_delay2", 32'(ld(2)), 32'd0);
    chk_val("t3_sets2", 32'(set_cnt[2] - snap_set[2]), 32'd64);

    // Link0 never ready -> timeout; link2 window 480..504 -> 480+12 = 492.
    delay_ready[0] = 1'b0;
    win_lo_a[2] = 480; win_hi_a[2] = 504;
    snap();
    run_cal(12'h005, 3000);
    chk_val("t4_link_ok", 32'(link_ok), 32'h004);
    chk_val("t4_delay2", 32'(ld(2)), 32'd492);
    chk_val("t4_sets0", 32'(set_cnt[0] - snap_set[0]), 32'd1);
    chk_val("t4_timeout_gap", 32'(fs_cyc[2] - fs_cyc[0]), 32'd34);
    delay_ready[0] = 1'b1;

    // Reset during link1 dwell, with an ignored start while busy.
    win_lo_a[1] = 0; win_hi_a[1] = 40;
    snap();
    start = 1'b1; link_mask = 12'h002;
    @(negedge clk160); start = 1'b0; link_mask = '0;
    @(negedge clk160);
    start = 1'b1; link_mask = 12'h800;
    @(negedge clk160); start = 1'b0; link_mask = '0;
    n = 0; found = 1'b0;
    while (!found && n < 100) begin
      if (reset_counters[1]) found = 1'b1;
      @(negedge clk160);
      n++;
    end
    chk_val("t5_clr_seen", 32'(found), 32'd1);
    chk_val("t5_busy_dwell", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk160);
    chk_val("t5_rst_busy", 32'(busy), 32'd0);
    chk_val("t5_rst_delay", 32'(link_delay != '0), 32'd0);
    chk_val("t5_rst_delay_in", 32'(delay_in != '0), 32'd0);
    chk_val("t5_rst_strobes", 32'({link_ok, delay_set, reset_counters, done}), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk160);
    chk_val("t5_stays_idle", 32'(busy), 32'd0);
    run_cal(12'h002, 2000);
    chk_val("t5_link_ok", 32'(link_ok), 32'h002);
    chk_val("t5_delay1", 32'(ld(1)), 32'd20);
    chk_val("t5_ignored_start", 32'(set_cnt[11] - snap_set[11]), 32'd0);

    chk_val("strobe_onehot", 32'(onehot_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
